nx_ram_arb: RTL and testbench
=============================

// Module: nx_ram_arb
// PURPOSE
//  Single-clock, N-channel shared RAM with round-robin arbitration, lane write
//  strobes and a fixed-latency tagged read response. Channels see valid/ready
//  requests and own one access slot per cycle. A post-reset clear sequencer
//  zeroes every word before service starts. Sits between node-local
//  instruction/state fetchers and a single inferred block RAM.
// PARAMETERS
//  CHANNELS     4     number of requesters (2..8)
//  DATA_WIDTH   36    word width
//  LANE_WIDTH   9     strobe granularity; DATA_WIDTH % LANE_WIDTH == 0
//  DEPTH        1024  words; power of two
//  READ_LATENCY 1     cycles from accepted read to rsp_valid_o (1 or 2)
//  (derived) ADDR_W = $clog2(DEPTH), LANES = DATA_WIDTH/LANE_WIDTH, ID_W = $clog2(CHANNELS)
// PORTS
//  clk_i         in   1                  clock
//  rst_ni        in   1                  reset, asynchronous, active-low
//  req_valid_i   in   CHANNELS           per-channel request valid
//  req_ready_o   out  CHANNELS           per-channel grant (one-hot or zero)
//  req_addr_i    in   CHANNELS*ADDR_W    packed addresses, channel 0 in LSBs
//  req_wr_i      in   CHANNELS           1 = write, 0 = read
//  req_data_i    in   CHANNELS*DATA_WIDTH packed write data
//  req_strb_i    in   CHANNELS*LANES     packed lane write enables
//  rsp_valid_o   out  1                  read data valid
//  rsp_id_o      out  ID_W               channel that issued the read
//  rsp_data_o    out  DATA_WIDTH         read data
//  init_done_o   out  1                  clear sequence complete
// BEHAVIOUR
//  Reset (rst_ni low): FSM=INIT, clear pointer=0, RR pointer=0, all outputs 0;
//   memory contents undefined until clear completes.
//  FSM INIT: writes 0 to word[ptr], ptr++ each cycle; req_ready_o=0.
//   After word DEPTH-1 written -> RUN, init_done_o=1 next cycle (DEPTH+1
//   cycles after reset release). ptr is ADDR_W+1 bits; no wrap.
//  FSM RUN: stays until reset. No other exits.
//  Arbitration (RUN only, combinational on req_valid_i): grant lowest channel
//   at or above RR pointer, wrapping from CHANNELS-1 to 0. Transfer when
//   req_valid_i[c] & req_ready_o[c]. After a transfer RR pointer = c+1 (mod
//   CHANNELS); with no transfer pointer holds. Max one grant per cycle;
//   req_ready_o never asserted for a channel with valid low.
//  Requesters hold addr/data/wr/strb stable while valid and not ready.
//  Write: lanes with strb=1 updated at the accepting edge; strb=0 lanes keep
//   old value; strb all-zero is a legal no-op write. No response for writes.
//  Read: rsp_valid_o/rsp_id_o/rsp_data_o asserted READ_LATENCY cycles after
//   the accepting edge, for exactly one cycle; no backpressure. rsp_data_o
//   holds last value when rsp_valid_o=0; rsp_id_o likewise.
//  Read-after-write same address on consecutive grants: read returns new data.
//  Back-to-back reads: one response per cycle, in acceptance order.
//  Reset mid-operation: in-flight responses dropped (rsp_valid_o=0
//   immediately), FSM back to INIT, clear restarts from word 0.
//  Out-of-range addresses impossible (ADDR_W exact).
// TESTING
//  1 Release reset, all valid=0 -> init_done_o rises at cycle DEPTH+1;
//    read every address -> all data 0.
//  2 All 4 channels valid continuously, reads -> grants 0,1,2,3,0,... ;
//    rsp_id_o follows same order, 1 cycle after each grant (READ_LATENCY=1).
//  3 Ch1 write addr 0x10 data 36'h123456789 strb 4'b1111, then write
//    data 36'hFFFFFFFFF strb 4'b0001 -> read 0x10 returns 36'h1234567FF.
//  4 Ch2 write addr 0x3FF then ch3 read 0x3FF next cycle -> new data returned.
//  5 READ_LATENCY=2: reads on ch0 at cycles t,t+1 -> rsp_valid_o at t+2,t+3,
//    ids 0,0, data in order.
//  6 Assert rst_ni low with a read in flight -> rsp_valid_o=0, req_ready_o=0,
//    init_done_o=0 immediately; after release, clear repeats from 0.

Source files
------------

// File: rtl/nx_ram_arb.sv
// rtl/nx_ram_arb.sv - N-channel round-robin shared RAM with lane strobes and tagged read response
// A post-reset sequencer zeroes the whole array before any channel is granted.
module nx_ram_arb #(
  parameter  int CHANNELS     = 4,
  parameter  int DATA_WIDTH   = 36,
  parameter  int LANE_WIDTH   = 9,
  parameter  int DEPTH        = 1024,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int LANES        = DATA_WIDTH / LANE_WIDTH,
  localparam int ID_W         = $clog2(CHANNELS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [CHANNELS-1:0]            req_valid_i,
  output logic [CHANNELS-1:0]            req_ready_o,
  input  logic [CHANNELS*ADDR_W-1:0]     req_addr_i,
  input  logic [CHANNELS-1:0]            req_wr_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] req_data_i,
  input  logic [CHANNELS*LANES-1:0]      req_strb_i,
  output logic                           rsp_valid_o,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic                           init_done_o
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_W:0]         r_ptr;
  logic [ID_W-1:0]         r_rr;
  logic                    r_init_done;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [CHANNELS-1:0]     w_gnt;
  logic [ID_W-1:0]         w_gnt_id;
  logic                    w_xfer;
  logic                    w_wr;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [LANES-1:0]        w_strb;

  logic                    r_v1;
  logic [ID_W-1:0]         r_id1;
  logic [DATA_WIDTH-1:0]   r_d1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (r_state == S_RUN);
      if (r_state == S_INIT) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_ptr == (ADDR_W+1)'(DEPTH-1)) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Search starts at the round-robin pointer; the first valid channel found wins.
  always_comb begin
    int c;
    c        = 0;
    w_gnt    = '0;
    w_gnt_id = '0;
    w_xfer   = 1'b0;
    if (r_state == S_RUN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        c = (int'(r_rr) + i) % CHANNELS;
        if (!w_xfer && req_valid_i[c]) begin
          w_xfer   = 1'b1;
          w_gnt[c] = 1'b1;
          w_gnt_id = ID_W'(c);
        end
      end
    end
  end

  assign req_ready_o = w_gnt;
  assign w_wr        = req_wr_i[w_gnt_id];
  assign w_addr      = req_addr_i[w_gnt_id*ADDR_W +: ADDR_W];
  assign w_wdata     = req_data_i[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_strb      = req_strb_i[w_gnt_id*LANES +: LANES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_xfer) begin
      r_rr <= (w_gnt_id == ID_W'(CHANNELS-1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_INIT) begin
      r_mem[r_ptr[ADDR_W-1:0]] <= '0;
    end else if (w_xfer && w_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_strb[l]) r_mem[w_addr][l*LANE_WIDTH +: LANE_WIDTH] <= w_wdata[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Data and id registers load only on an accepted read so they hold between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1  <= 1'b0;
      r_id1 <= '0;
      r_d1  <= '0;
    end else begin
      r_v1 <= w_xfer && !w_wr;
      if (w_xfer && !w_wr) begin
        r_id1 <= w_gnt_id;
        r_d1  <= r_mem[w_addr];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_v2;
    logic [ID_W-1:0]       r_id2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_v2  <= 1'b0;
        r_id2 <= '0;
        r_d2  <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_id2 <= r_id1;
          r_d2  <= r_d1;
        end
      end
    end

    assign rsp_valid_o = r_v2;
    assign rsp_id_o    = r_id2;
    assign rsp_data_o  = r_d2;
  end else begin : g_lat1
    assign rsp_valid_o = r_v1;
    assign rsp_id_o    = r_id1;
    assign rsp_data_o  = r_d1;
  end

  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_nx_ram_arb.sv
// tb/tb_nx_ram_arb.sv - directed bench for nx_ram_arb; read latency 1 and 2 instances share stimulus
module tb_nx_ram_arb;
  localparam int CH = 4, DW = 36, AW = 10, LN = 4, DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   valid = '0;
  logic [CH-1:0]   wr_v = '0;
  logic [CH*AW-1:0] addr = '0;
  logic [CH*DW-1:0] data = '0;
  logic [CH*LN-1:0] strb = '0;

  logic [CH-1:0]   rdy1, rdy2;
  logic            rv1, rv2, done1, done2;
  logic [1:0]      id1, id2;
  logic [DW-1:0]   rd1, rd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nx_ram_arb #(.READ_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(rdy1),
    .req_addr_i(addr), .req_wr_i(wr_v), .req_data_i(data), .req_strb_i(strb),
    .rsp_valid_o(rv1), .rsp_id_o(id1), .rsp_data_o(rd1), .init_done_o(done1)
  );

  nx_ram_arb #(.READ_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(rdy2),
    .req_addr_i(addr), .req_wr_i(wr_v), .req_data_i(data), .req_strb_i(strb),
    .rsp_valid_o(rv2), .rsp_id_o(id2), .rsp_data_o(rd2), .init_done_o(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge just after reset release.
  task automatic wait_init(input string tag);
    repeat (DEPTH) @(negedge clk);
    check({tag, " done low at DEPTH"}, {done1, done2}, 2'b00);
    @(negedge clk);
    check({tag, " done high at DEPTH+1"}, {done1, done2}, 2'b11);
  endtask

  // Starts and returns at a negedge; valid drops after the accepting edge.
  task automatic xfer(input int ch, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [LN-1:0] s, input string tag);
    int n;
    n = 0;
    valid[ch] = 1'b1;
    wr_v[ch]  = w;
    addr[ch*AW +: AW] = a;
    data[ch*DW +: DW] = d;
    strb[ch*LN +: LN] = s;
    #1;
    while (!rdy1[ch] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " grant"}, rdy1[ch], 1'b1);
    @(negedge clk);
    valid[ch] = 1'b0;
  endtask

  task automatic rd_check(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    logic [1:0] idv;
    idv = ch[1:0];
    xfer(ch, 1'b0, a, '0, '0, tag);
    check({tag, " lat1 rsp"}, {rv1, id1, rd1}, {1'b1, idv, exp});
    @(negedge clk);
    check({tag, " lat2 rsp"}, {rv2, id2, rd2}, {1'b1, idv, exp});
    check({tag, " lat1 single"}, rv1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt1, cnt2, miss;
    logic [DW-1:0] or1, or2;
    logic [CH-1:0] exp_g [8];
    logic [1:0]    exp_id [8];

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {rv1, rv2, done1, done2, rdy1, rdy2, rd1, rd2}, '0);

    // 1: clear sequence timing and every word zero
    rst_n = 1'b1;
    wait_init("t1");
    cnt1 = 0; cnt2 = 0; miss = 0; or1 = '0; or2 = '0;
    for (int a = 0; a <= DEPTH + 1; a++) begin
      if (rv1) begin cnt1++; or1 |= rd1; end
      if (rv2) begin cnt2++; or2 |= rd2; end
      if (a < DEPTH) begin
        valid[0] = 1'b1;
        addr[AW-1:0] = AW'(a);
        #1;
        if (!rdy1[0]) miss++;
      end else begin
        valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    check("t1 grant misses", miss, 0);
    check("t1 lat1 rsp count", cnt1, DEPTH);
    check("t1 lat2 rsp count", cnt2, DEPTH);
    check("t1 lat1 data zero", or1, '0);
    check("t1 lat2 data zero", or2, '0);

    // 2: all channels reading; RR pointer is 1 after the channel-0 sweep
    exp_g  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < CH; c++) addr[c*AW +: AW] = AW'(c);
    wr_v  = '0;
    valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("t2 grant %0d", k), rdy1, exp_g[k]);
      if (k > 0) check($sformatf("t2 rsp id %0d", k - 1), {rv1, id1}, {1'b1, exp_id[k-1]});
      @(negedge clk);
    end
    valid = '0;
    check("t2 rsp id 7", {rv1, id1}, {1'b1, exp_id[7]});
    @(negedge clk);

    // 3: lane strobes on ch1
    xfer(1, 1'b1, 10'h010, 36'h123456789, 4'b1111, "t3 wr full");
    xfer(1, 1'b1, 10'h010, 36'hFFFFFFFFF, 4'b0001, "t3 wr lane0");
    rd_check(1, 10'h010, 36'h1234567FF, "t3 rd lane0");
    xfer(1, 1'b1, 10'h010, 36'h000000000, 4'b0000, "t3 wr nostrb");
    rd_check(1, 10'h010, 36'h1234567FF, "t3 rd nostrb");
    xfer(1, 1'b1, 10'h010, 36'h000000000, 4'b1000, "t3 wr lane3");
    rd_check(1, 10'h010, 36'h0034567FF, "t3 rd lane3");

    // 4: ch2 write then ch3 read same address on consecutive grants (RR pointer = 2)
    @(negedge clk);
    valid[2] = 1'b1; wr_v[2] = 1'b1; addr[2*AW +: AW] = 10'h3FF;
    data[2*DW +: DW] = 36'hABCDE1234; strb[2*LN +: LN] = 4'hF;
    valid[3] = 1'b1; wr_v[3] = 1'b0; addr[3*AW +: AW] = 10'h3FF;
    #1;
    check("t4 grant ch2", rdy1, 4'b0100);
    @(negedge clk);
    valid[2] = 1'b0;
    #1;
    check("t4 grant ch3", rdy1, 4'b1000);
    @(negedge clk);
    valid[3] = 1'b0;
    check("t4 lat1 raw", {rv1, id1, rd1}, {1'b1, 2'd3, 36'hABCDE1234});
    @(negedge clk);
    check("t4 lat2 raw", {rv2, id2, rd2}, {1'b1, 2'd3, 36'hABCDE1234});

    // 5: back-to-back reads on ch0
    @(negedge clk);
    valid[0] = 1'b1; wr_v[0] = 1'b0; addr[AW-1:0] = 10'h010;
    #1;
    check("t5 grant a", rdy1[0], 1'b1);
    @(negedge clk);
    addr[AW-1:0] = 10'h3FF;
    #1;
    check("t5 grant b", rdy1[0], 1'b1);
    check("t5 lat1 first", {rv1, id1, rd1}, {1'b1, 2'd0, 36'h0034567FF});
    check("t5 lat2 none yet", rv2, 1'b0);
    @(negedge clk);
    valid[0] = 1'b0;
    check("t5 lat1 second", {rv1, id1, rd1}, {1'b1, 2'd0, 36'hABCDE1234});
    check("t5 lat2 first", {rv2, id2, rd2}, {1'b1, 2'd0, 36'h0034567FF});
    @(negedge clk);
    check("t5 lat2 second", {rv2, id2, rd2}, {1'b1, 2'd0, 36'hABCDE1234});
    check("t5 lat1 hold", {rv1, id1, rd1}, {1'b0, 2'd0, 36'hABCDE1234});
    @(negedge clk);
    check("t5 lat2 hold", {rv2, id2, rd2}, {1'b0, 2'd0, 36'hABCDE1234});

    // 6: reset with reads in flight
    valid[0] = 1'b1; addr[AW-1:0] = 10'h010;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async clear", {rv1, rv2, done1, done2, rdy1, rdy2}, '0);
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("t6");
    rd_check(0, 10'h010, 36'h0, "t6 rd cleared");
    rd_check(0, 10'h3FF, 36'h0, "t6 rd cleared top");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
